// File: rtl/psum_stream_tx_pkg.sv
// Shared widths, saturation limits, FSM encoding and lane clamp helper for psum_stream_tx.
package psum_stream_tx_pkg;
  localparam int PSUM_W    = 24;
  localparam int LANES     = 16;
  localparam int ROWS      = 16;
  localparam int ROW_W     = LANES * PSUM_W;
  localparam int ROW_IDX_W = $clog2(ROWS);

  localparam logic [PSUM_W-1:0] PSUM_MAX = 24'h7FFFFF;
  localparam logic [PSUM_W-1:0] PSUM_MIN = 24'h800000;

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    WAIT_PPU = 2'd1,
    STREAM   = 2'd2
  } state_t;

  // A 25-bit sum overflowed 24 bits when its top two bits disagree.
  function automatic logic [PSUM_W-1:0] sat_clamp(input logic [PSUM_W:0] s);
    logic [PSUM_W-1:0] r;
    if (s[PSUM_W] != s[PSUM_W-1]) r = s[PSUM_W] ? PSUM_MIN : PSUM_MAX;
    else                          r = s[PSUM_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/psum_stream_tx_sat_add.sv
// Combinational 16-lane signed saturating adder with an OR of the per-lane clamp flags.
module psum_sat_add
  import psum_stream_tx_pkg::*;
(
  input  logic [ROW_W-1:0] a,
  input  logic [ROW_W-1:0] b,
  output logic [ROW_W-1:0] sum,
  output logic             ovf
);

  logic [LANES-1:0] lane_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PSUM_W-1:0] a_lane;
    logic [PSUM_W-1:0] b_lane;
    logic [PSUM_W:0]   s;

    assign a_lane = a[i*PSUM_W +: PSUM_W];
    assign b_lane = b[i*PSUM_W +: PSUM_W];
    assign s = {a_lane[PSUM_W-1], a_lane} + {b_lane[PSUM_W-1], b_lane};
    assign lane_ovf[i] = (s[PSUM_W] != s[PSUM_W-1]);
    assign sum[i*PSUM_W +: PSUM_W] = sat_clamp(s);
  end

  assign ovf = |lane_ovf;

endmodule

// File: rtl/psum_stream_tx.sv
// Partial-sum accumulator and 16-beat burst transmitter feeding the PPU.
// Define PSUM_DOUBLE_BUF_EN for two ping-pong buffer banks (fill one while the other streams).
module psum_stream_tx
  import psum_stream_tx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROW_IDX_W-1:0] in_row,
  input  logic [ROW_W-1:0]     in_data,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic                 cfg_load,
  input  logic [7:0]           scale_in,
  input  logic [7:0]           bias_in,
  input  logic                 ppu_ready,
  output logic [ROW_W-1:0]     partial_sum,
  output logic [7:0]           scale,
  output logic [7:0]           bias,
  output logic                 valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam logic [ROW_IDX_W-1:0] LAST_BEAT = ROW_IDX_W'(ROWS - 1);

  state_t                 state, next_state;
  logic [7:0]             scale_sh, bias_sh;
  logic [ROW_IDX_W-1:0]   beat;
  logic                   accept;
  logic [ROWS-1:0]        mask_next;

`ifdef PSUM_DOUBLE_BUF_EN

  logic [ROW_W-1:0] buf_q [2][ROWS];
  logic [ROWS-1:0]  last_mask [2];
  logic [1:0]       ovf_q;
  logic [1:0]       full_q;
  logic             fill_sel, str_sel;
  logic [ROW_W-1:0] sum_row [2];
  logic [1:0]       sum_ovf;
  logic             fill_done;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    psum_sat_add u_add (
      .a   (buf_q[b][in_row]),
      .b   (in_data),
      .sum (sum_row[b]),
      .ovf (sum_ovf[b])
    );
  end

  assign in_ready  = !full_q[fill_sel];
  assign accept    = in_valid && in_ready;
  assign fill_done = accept && (&mask_next);
  assign busy      = (state != ACCUM);
  assign overflow  = busy ? ovf_q[str_sel] : ovf_q[fill_sel];

  always_comb begin
    mask_next = last_mask[fill_sel];
    if (accept && in_last) mask_next[in_row] = 1'b1;
  end

  // Stream side idles in ACCUM until the bank it owns next is complete.
  always_comb begin
    next_state = state;
    case (state)
      ACCUM:    if (full_q[str_sel] || (fill_done && (fill_sel == str_sel))) next_state = WAIT_PPU;
      WAIT_PPU: if (ppu_ready) next_state = STREAM;
      STREAM:   if (beat == LAST_BEAT) next_state = ACCUM;
      default:  next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        last_mask[b] <= '0;
        for (int r = 0; r < ROWS; r++) buf_q[b][r] <= '0;
      end
      ovf_q       <= '0;
      full_q      <= '0;
      fill_sel    <= 1'b0;
      str_sel     <= 1'b0;
      scale_sh    <= '0;
      bias_sh     <= '0;
      scale       <= '0;
      bias        <= '0;
      partial_sum <= '0;
      valid       <= 1'b0;
      beat        <= '0;
    end else begin
      if (cfg_load) begin
        scale_sh <= scale_in;
        bias_sh  <= bias_in;
      end
      if (accept) begin
        buf_q[fill_sel][in_row] <= in_first ? in_data : sum_row[fill_sel];
        if (!in_first && sum_ovf[fill_sel]) ovf_q[fill_sel] <= 1'b1;
        last_mask[fill_sel] <= mask_next;
        if (&mask_next) begin
          full_q[fill_sel] <= 1'b1;
          fill_sel         <= ~fill_sel;
        end
      end
      case (state)
        WAIT_PPU: if (ppu_ready) begin
          scale       <= scale_sh;
          bias        <= bias_sh;
          partial_sum <= buf_q[str_sel][0];
          valid       <= 1'b1;
          beat        <= '0;
        end
        STREAM: if (beat == LAST_BEAT) begin
          valid              <= 1'b0;
          partial_sum        <= '0;
          full_q[str_sel]    <= 1'b0;
          last_mask[str_sel] <= '0;
          ovf_q[str_sel]     <= 1'b0;
          str_sel            <= ~str_sel;
        end else begin
          beat        <= beat + 1'b1;
          partial_sum <= buf_q[str_sel][beat + 1'b1];
        end
        default: ;
      endcase
    end
  end

`else

  logic [ROW_W-1:0] buf_q [ROWS];
  logic [ROWS-1:0]  last_mask;
  logic             ovf_q;
  logic [ROW_W-1:0] sum_row;
  logic             sum_ovf;

  psum_sat_add u_add (
    .a   (buf_q[in_row]),
    .b   (in_data),
    .sum (sum_row),
    .ovf (sum_ovf)
  );

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ACCUM);
  assign overflow = ovf_q;

  always_comb begin
    mask_next = last_mask;
    if (accept && in_last) mask_next[in_row] = 1'b1;
  end

  // Completion includes the beat accepted this cycle so WAIT_PPU follows immediately.
  always_comb begin
    next_state = state;
    case (state)
      ACCUM:    if (&mask_next) next_state = WAIT_PPU;
      WAIT_PPU: if (ppu_ready) next_state = STREAM;
      STREAM:   if (beat == LAST_BEAT) next_state = ACCUM;
      default:  next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) buf_q[r] <= '0;
      last_mask   <= '0;
      ovf_q       <= 1'b0;
      scale_sh    <= '0;
      bias_sh     <= '0;
      scale       <= '0;
      bias        <= '0;
      partial_sum <= '0;
      valid       <= 1'b0;
      beat        <= '0;
    end else begin
      if (cfg_load) begin
        scale_sh <= scale_in;
        bias_sh  <= bias_in;
      end
      case (state)
        ACCUM: if (accept) begin
          buf_q[in_row] <= in_first ? in_data : sum_row;
          if (!in_first && sum_ovf) ovf_q <= 1'b1;
          last_mask <= mask_next;
        end
        WAIT_PPU: if (ppu_ready) begin
          scale       <= scale_sh;
          bias        <= bias_sh;
          partial_sum <= buf_q[0];
          valid       <= 1'b1;
          beat        <= '0;
        end
        STREAM: if (beat == LAST_BEAT) begin
          valid       <= 1'b0;
          partial_sum <= '0;
          last_mask   <= '0;
          ovf_q       <= 1'b0;
        end else begin
          beat        <= beat + 1'b1;
          partial_sum <= buf_q[beat + 1'b1];
        end
        default: ;
      endcase
    end
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= next_state;
  end

endmodule

// File: tb/tb_psum_stream_tx.sv
// Self-checking bench for psum_stream_tx (single-bank build) against an integer tile model.
module tb_psum_stream_tx;
  import psum_stream_tx_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROW_IDX_W-1:0] in_row;
  logic [ROW_W-1:0]     in_data;
  logic                 in_first;
  logic                 in_last;
  logic                 cfg_load;
  logic [7:0]           scale_in;
  logic [7:0]           bias_in;
  logic                 ppu_ready;
  logic [ROW_W-1:0]     partial_sum;
  logic [7:0]           scale;
  logic [7:0]           bias;
  logic                 valid;
  logic                 overflow;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: tile contents as plain integers plus the config shadow.
  int         mbuf [ROWS][LANES];
  bit         model_ovf;
  logic [7:0] sh_scale, sh_bias;
  logic [7:0] nxt_scale, nxt_bias;

  psum_stream_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .in_data     (in_data),
    .in_first    (in_first),
    .in_last     (in_last),
    .cfg_load    (cfg_load),
    .scale_in    (scale_in),
    .bias_in     (bias_in),
    .ppu_ready   (ppu_ready),
    .partial_sum (partial_sum),
    .scale       (scale),
    .bias        (bias),
    .valid       (valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [ROW_W-1:0] obs,
                              input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < LANES; i++) mbuf[r][i] = 0;
    model_ovf = 1'b0;
  endfunction

  function automatic void model_beat(input int row, input logic [ROW_W-1:0] d, input bit first);
    for (int i = 0; i < LANES; i++) begin
      logic signed [PSUM_W-1:0] l;
      int x, s;
      l = d[i*PSUM_W +: PSUM_W];
      x = int'(l);
      if (first) begin
        mbuf[row][i] = x;
      end else begin
        s = mbuf[row][i] + x;
        if (s > 8388607) begin
          s = 8388607;
          model_ovf = 1'b1;
        end else if (s < -8388608) begin
          s = -8388608;
          model_ovf = 1'b1;
        end
        mbuf[row][i] = s;
      end
    end
  endfunction

  function automatic logic [ROW_W-1:0] model_row(input int r);
    logic [ROW_W-1:0] res;
    int v;
    for (int i = 0; i < LANES; i++) begin
      v = mbuf[r][i];
      res[i*PSUM_W +: PSUM_W] = v[PSUM_W-1:0];
    end
    return res;
  endfunction

  function automatic logic [PSUM_W-1:0] rand_lane();
    int v;
    if ($urandom_range(0, 3) == 0) begin
      v = int'($urandom());
    end else begin
      v = int'($urandom_range(0, 4000)) - 2000;
    end
    return v[PSUM_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] res;
    for (int i = 0; i < LANES; i++) res[i*PSUM_W +: PSUM_W] = rand_lane();
    return res;
  endfunction

  function automatic logic [ROW_W-1:0] fill_row(input int v);
    logic [ROW_W-1:0] res;
    for (int i = 0; i < LANES; i++) res[i*PSUM_W +: PSUM_W] = v[PSUM_W-1:0];
    return res;
  endfunction

  task automatic apply_stimulus(input int row, input logic [ROW_W-1:0] d,
                                input bit first, input bit last);
    check_output("ready_accum", in_ready, 1'b1);
    in_valid = 1'b1;
    in_row   = ROW_IDX_W'(row);
    in_data  = d;
    in_first = first;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    model_beat(row, d, first);
  endtask

  task automatic do_cfg(input logic [7:0] s, input logic [7:0] b);
    scale_in = s;
    bias_in  = b;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    sh_scale = s;
    sh_bias  = b;
  endtask

  // K=1 tile: pattern rows carry row*16+lane, otherwise random rows.
  task automatic send_k1(input bit pattern);
    logic [ROW_W-1:0] d;
    for (int r = 0; r < ROWS; r++) begin
      if (pattern) begin
        for (int i = 0; i < LANES; i++) d[i*PSUM_W +: PSUM_W] = PSUM_W'(r*16 + i);
      end else begin
        d = rand_row();
      end
      apply_stimulus(r, d, 1'b1, 1'b1);
      if (r < ROWS-1) check_output("early_done", busy, 1'b0);
    end
  endtask

  task automatic rand_tile(input int k_tiles);
    for (int k = 0; k < k_tiles; k++) begin
      for (int r = 0; r < ROWS; r++) begin
        apply_stimulus(r, rand_row(), k == 0, (k == k_tiles-1) || (r == 0));
        if (!((k == k_tiles-1) && (r == ROWS-1))) check_output("early_done", busy, 1'b0);
      end
    end
  endtask

  task automatic sat_tile(input logic [PSUM_W-1:0] v0, input logic [PSUM_W-1:0] v1);
    logic [ROW_W-1:0] d;
    for (int r = 0; r < ROWS; r++) begin
      d = rand_row();
      if (r == 4) d[7*PSUM_W +: PSUM_W] = v0;
      apply_stimulus(r, d, 1'b1, r != 4);
      check_output("early_done", busy, 1'b0);
    end
    d = '0;
    d[7*PSUM_W +: PSUM_W] = v1;
    apply_stimulus(4, d, 1'b0, 1'b1);
  endtask

  // Called one sample before the first beat is due; checks all 16 beats and the return to ACCUM.
  task automatic check_burst(input int cfg_beat, input int drop_beat);
    logic [7:0] es, eb;
    es = sh_scale;
    eb = sh_bias;
    check_output("pre_valid", valid, 1'b0);
    check_output("pre_ready", in_ready, 1'b0);
    step();
    for (int k = 0; k < ROWS; k++) begin
      check_output($sformatf("beat%0d_valid", k), valid, 1'b1);
      check_output($sformatf("beat%0d_data", k), partial_sum, model_row(k));
      check_output($sformatf("beat%0d_scale", k), scale, es);
      check_output($sformatf("beat%0d_bias", k), bias, eb);
      check_output($sformatf("beat%0d_ovf", k), overflow, model_ovf);
      check_output($sformatf("beat%0d_ready", k), in_ready, 1'b0);
      check_output($sformatf("beat%0d_busy", k), busy, 1'b1);
      if (k == cfg_beat) begin
        scale_in = nxt_scale;
        bias_in  = nxt_bias;
        cfg_load = 1'b1;
        sh_scale = nxt_scale;
        sh_bias  = nxt_bias;
      end
      if (k == drop_beat) ppu_ready = 1'b0;
      step();
      cfg_load = 1'b0;
    end
    check_output("post_valid", valid, 1'b0);
    check_output("post_data", partial_sum, '0);
    check_output("post_ovf", overflow, 1'b0);
    check_output("post_ready", in_ready, 1'b1);
    check_output("post_busy", busy, 1'b0);
    model_ovf = 1'b0;
    ppu_ready = 1'b1;
  endtask

  initial begin
    int kv [3];
    kv = '{100, -30, 5};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_row    = '0;
    in_data   = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    cfg_load  = 1'b0;
    scale_in  = '0;
    bias_in   = '0;
    ppu_ready = 1'b1;
    sh_scale  = '0;
    sh_bias   = '0;
    nxt_scale = '0;
    nxt_bias  = '0;
    model_clear();
    $display("[TB] start");

    step();
    step();
    check_output("rst_data", partial_sum, '0);
    check_output("rst_scale", scale, '0);
    check_output("rst_bias", bias, '0);
    check_output("rst_valid", valid, 1'b0);
    check_output("rst_ovf", overflow, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    $display("[TB] K=1 pattern tile, config 3/9 then 5/9 mid-burst");
    do_cfg(8'd3, 8'd9);
    nxt_scale = 8'd5;
    nxt_bias  = 8'd9;
    send_k1(1'b1);
    check_burst(4, -1);

    $display("[TB] K=3 accumulate 100, -30, 5");
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < ROWS; r++) begin
        apply_stimulus(r, fill_row(kv[k]), k == 0, k == 2);
        if (!((k == 2) && (r == ROWS-1))) check_output("early_done", busy, 1'b0);
      end
    check_burst(-1, -1);

    $display("[TB] saturation high and low");
    sat_tile(24'h7FFFF0, 24'h000020);
    check_burst(-1, -1);
    sat_tile(24'h800010, 24'hFFFFE0);
    check_burst(-1, -1);

    $display("[TB] back-pressure with ignored input and ppu_ready drop mid-burst");
    ppu_ready = 1'b0;
    send_k1(1'b0);
    for (int j = 0; j < 10; j++) begin
      check_output("bp_valid", valid, 1'b0);
      check_output("bp_ready", in_ready, 1'b0);
      check_output("bp_busy", busy, 1'b1);
      in_valid = 1'b1;
      in_row   = ROW_IDX_W'($urandom_range(0, ROWS-1));
      in_data  = rand_row();
      step();
    end
    in_valid  = 1'b0;
    ppu_ready = 1'b1;
    check_burst(-1, 5);

    $display("[TB] random multi-K tiles");
    for (int t = 0; t < 3; t++) begin
      rand_tile($urandom_range(2, 4));
      check_burst(-1, -1);
    end

    $display("[TB] reset at beat 6");
    send_k1(1'b0);
    for (int j = 0; j < 7; j++) step();
    check_output("rst6_pre_valid", valid, 1'b1);
    check_output("rst6_pre_data", partial_sum, model_row(6));
    rst_n = 1'b0;
    #1;
    check_output("rst6_valid", valid, 1'b0);
    check_output("rst6_ready", in_ready, 1'b1);
    check_output("rst6_busy", busy, 1'b0);
    check_output("rst6_data", partial_sum, '0);
    check_output("rst6_scale", scale, '0);
    model_clear();
    sh_scale = '0;
    sh_bias  = '0;
    #3;
    rst_n = 1'b1;
    send_k1(1'b0);
    check_burst(-1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
